seq_sixtyfour_bit_adder: RTL and testbench
==========================================

Name: seq_sixtyfour_bit_adder

Overview:
Area-reduced 64-bit adder. It computes S = A + B + Cin over four clock cycles by reusing one sixteen_bit_adder slice, one 16-bit chunk per cycle, LSB chunk first. It sits at the front of the datapath as the multicycle alternative to the fully combinational 64-bit ripple adder. A start/busy/done handshake sequences it, and it reports the same S/Cout plus a signed-overflow flag.

Parameters:
WIDTH, 64, total operand width; must equal CHUNK_W * NUM_CHUNKS.
CHUNK_W, 16, width of the reused adder slice. Fixed at 16 to match sixteen_bit_adder.
NUM_CHUNKS, 4, number of compute cycles (WIDTH/CHUNK_W).

Ports:
clk  input  1  rising-edge clock; the block's only clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
A  input  64  operand A; sampled on the accepting edge only.
B  input  64  operand B; sampled on the accepting edge only.
Cin  input  1  carry in; sampled on the accepting edge only.
S  output  64  registered sum; holds its value until the next accepted start.
Cout  output  1  registered carry out of bit 63.
overflow  output  1  registered signed overflow: (A[63]==B[63]) && (S[63]!=A[63]).
busy  output  1  high while in CALC.
done  output  1  one-cycle pulse; S/Cout/overflow are final while it is high.

Behaviour:
- Reset (synchronous, sampled on the clk edge): state=IDLE, S=0, Cout=0, overflow=0, busy=0, done=0, chunk index=0, internal carry=0, operand registers=0.
- Reset wins over start on the same edge.
- Reset mid-CALC aborts the operation; no done is generated.
- FSM states: IDLE, CALC, DONE.
  - IDLE, start=1: latch A, B, Cin into operand registers; carry_reg=Cin; idx=0; clear S, Cout, overflow to 0; go to CALC.
  - IDLE, start=0: stay in IDLE.
  - CALC, every edge: the slice adds opA[16*idx+:16] + opB[16*idx+:16] + carry_reg.
    - The sum is written to S[16*idx+:16].
    - The slice carry-out is written to carry_reg.
    - idx increments.
  - CALC, edge with idx==3: also set Cout = slice carry, compute overflow from the latched sign bits and the new S[63], then go to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1: accept new operands exactly as in IDLE (back-to-back, no idle bubble) and go to CALC.
    - start=0: go to IDLE.
- Latency: accepting edge E0; compute edges E1..E4; done is high in the cycle after E4. That is 5 cycles from the start sample to done.
- Throughput: one result per 5 cycles.
- busy=1 exactly in CALC.
- start asserted during CALC is ignored (not queued).
- A, B, Cin may change freely after E0 without affecting the result.
- S, Cout and overflow are only valid when done=1 or afterwards, until the next accepted start.
  - Partial S is visible during CALC; consumers must not use it.
- Arithmetic: unsigned modulo 2^64 with the carry out on Cout. The result equals the combinational 64-bit ripple adder for all inputs.
- The slice is instantiated with port order (Cout, S, A, B, Cin).
- Chunk multiplexing is by idx; no other adders are used.

Test Plan:
- Reset held for 3 cycles, then released -> S=0, Cout=0, overflow=0, busy=0, done=0; stays in IDLE with start=0.
- A=1, B=1, Cin=0, start pulsed -> busy high for 4 cycles; done high exactly 5 cycles after the start edge; S=2, Cout=0, overflow=0.
- A=FFFF_FFFF_FFFF_FFFF, B=0, Cin=1 -> carry ripples through all four chunks; S=0, Cout=1, overflow=0. Also A=0000_0000_0000_FFFF, B=1, Cin=0 -> S=0000_0000_0001_0000.
- A=7FFF_FFFF_FFFF_FFFF, B=1, Cin=0 -> S=8000_0000_0000_0000, Cout=0, overflow=1. Also A=B=8000_0000_0000_0000 -> S=0, Cout=1, overflow=1.
- Start held high continuously with operands changed mid-CALC -> the changes are ignored. The new start is taken in the DONE cycle, giving done pulses every 5 cycles. Each result matches the operands present on its accepting edge.
- Reset asserted on the 2nd CALC cycle -> all outputs are 0 next cycle; no done pulse. A new start afterwards gives the correct result.
- Randomised check: 1000 random A/B/Cin -> {Cout,S} equals the 65-bit reference sum, and overflow matches the sign rule.

Source files
------------

// File: rtl/seq_sixtyfour_bit_adder.sv
// seq_sixtyfour_bit_adder
//   Multicycle 64-bit adder: S = A + B + Cin, computed one 16-bit chunk per
//   cycle (LSB chunk first) on a single reused sixteen_bit_adder slice.
//   A start/busy/done handshake sequences it; a new operation may be
//   accepted in the DONE cycle with no idle bubble.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   start     in   request; sampled only in IDLE or DONE
//   A, B      in   64-bit operands, latched on the accepting edge
//   Cin       in   carry in, latched on the accepting edge
//   S         out  registered sum (partial during CALC, final from done on)
//   Cout      out  registered carry out of bit 63
//   overflow  out  registered signed overflow
//   busy      out  high while in CALC
//   done      out  one-cycle pulse when S/Cout/overflow are final

// sixteen_bit_adder
//   Combinational 16-bit ripple-carry adder, port order (Cout, S, A, B, Cin).
module sixteen_bit_adder (
  output logic        Cout,
  output logic [15:0] S,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin
);

  logic [16:0] carry;

  // Bitwise full-adder ripple chain.
  always_comb begin
    S        = '0;
    carry    = '0;
    carry[0] = Cin;
    for (int i = 0; i < 16; i++) begin
      S[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout = carry[16];

endmodule

module seq_sixtyfour_bit_adder #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned CHUNK_W    = 16,
  parameter int unsigned NUM_CHUNKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic               accept_c;
  logic               last_c;

  logic [IDX_W-1:0]   idx;
  logic               carry_reg;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;

  logic [CHUNK_W-1:0] slice_a;
  logic [CHUNK_W-1:0] slice_b;
  logic [CHUNK_W-1:0] slice_s;
  logic               slice_c;

  // Chunk selection from the latched operands, steered by idx.
  assign slice_a = op_a[CHUNK_W*idx +: CHUNK_W];
  assign slice_b = op_b[CHUNK_W*idx +: CHUNK_W];

  sixteen_bit_adder u_slice (
    .Cout (slice_c),
    .S    (slice_s),
    .A    (slice_a),
    .B    (slice_b),
    .Cin  (carry_reg)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; accept_c marks an edge that latches new operands,
  // last_c marks the edge computing the top chunk.
  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_n  = CALC;
        end
      end
      CALC: begin
        if (idx == IDX_W'(NUM_CHUNKS - 1)) begin
          last_c  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_n  = CALC;
        end else begin
          state_n  = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a      <= '0;
      op_b      <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      S         <= '0;
      Cout      <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_n == CALC);
      done <= (state_n == DONE);
      if (accept_c) begin
        op_a      <= A;
        op_b      <= B;
        carry_reg <= Cin;
        idx       <= '0;
        S         <= '0;
        Cout      <= 1'b0;
        overflow  <= 1'b0;
      end else if (state == CALC) begin
        S[CHUNK_W*idx +: CHUNK_W] <= slice_s;
        carry_reg                 <= slice_c;
        idx                       <= IDX_W'(idx + 1'b1);
        if (last_c) begin
          Cout     <= slice_c;
          // Signed overflow: like-signed operands with a sum of the other sign.
          overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                      (slice_s[CHUNK_W-1] != op_a[WIDTH-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_sixtyfour_bit_adder.sv
// Testbench for seq_sixtyfour_bit_adder: directed vectors with hand-computed
// results, back-to-back starts, mid-CALC reset and a random sweep.
module tb_seq_sixtyfour_bit_adder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [63:0] s;
  logic        cout;
  logic        overflow;
  logic        busy;
  logic        done;

  int n_checks;
  int n_pass;

  seq_sixtyfour_bit_adder dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (a),
    .B        (b),
    .Cin      (cin),
    .S        (s),
    .Cout     (cout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation; operands are scrambled and start is re-pulsed
  // during CALC, neither of which may affect the result.
  task automatic do_op(input string tag, input logic [63:0] va, input logic [63:0] vb,
                       input logic vc, input logic [63:0] es, input logic ec,
                       input logic eov);
    int edges;
    int busy_cnt;
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();                       // accepting edge
    start = 1'b0;
    a = ~va; b = va ^ vb; cin = ~vc;
    busy_cnt = busy ? 1 : 0;
    edges = 0;
    while (!done && edges < 10) begin
      if (edges == 1) start = 1'b1;
      if (edges == 3) start = 1'b0;
      tick();
      edges++;
      if (busy) busy_cnt++;
    end
    check({tag, "_lat"}, 65'(edges), 65'd4);
    check({tag, "_busy"}, 65'(busy_cnt), 65'd4);
    check({tag, "_sum"}, {cout, s}, {ec, es});
    check({tag, "_ovf"}, 65'(overflow), 65'(eov));
    tick();
    check({tag, "_pulse"}, 65'({done, busy}), 65'd0);
  endtask

  logic [63:0] bb_a [3];
  logic [63:0] bb_b [3];
  logic        bb_c [3];
  logic [63:0] bb_s [3];
  logic        bb_co[3];
  logic        bb_ov[3];

  initial begin
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] rsum;
    logic        rov;
    int          edges;
    int          seen_done;

    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    a = 64'hDEAD_BEEF_0000_1111; start = 1'b1;   // reset must win over start
    repeat (3) tick();
    start = 1'b0;
    reset = 1'b0;
    check("rst_sum", {cout, s}, 65'd0);
    check("rst_flags", 65'({overflow, busy, done}), 65'd0);
    repeat (3) tick();
    check("idle_hold", 65'({busy, done}), 65'd0);

    do_op("one_plus_one", 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0);
    do_op("ripple_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    do_op("ripple_one", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
          64'h0000_0000_0001_0000, 1'b0, 1'b0);
    do_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
          64'd0, 1'b1, 1'b1);

    // Back-to-back with start held high.
    bb_a[0] = 64'h1234_5678_9ABC_DEF0; bb_b[0] = 64'h1111_1111_1111_1111; bb_c[0] = 1'b0;
    bb_s[0] = 64'h2345_6789_ABCD_F001; bb_co[0] = 1'b0; bb_ov[0] = 1'b0;
    bb_a[1] = 64'hFFFF_0000_FFFF_0000; bb_b[1] = 64'h0001_0000_0001_0000; bb_c[1] = 1'b1;
    bb_s[1] = 64'h0000_0001_0000_0001; bb_co[1] = 1'b1; bb_ov[1] = 1'b0;
    bb_a[2] = 64'h4000_0000_0000_0000; bb_b[2] = 64'h4000_0000_0000_0000; bb_c[2] = 1'b0;
    bb_s[2] = 64'h8000_0000_0000_0000; bb_co[2] = 1'b0; bb_ov[2] = 1'b1;
    a = bb_a[0]; b = bb_b[0]; cin = bb_c[0]; start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        a = bb_a[i+1]; b = bb_b[i+1]; cin = bb_c[i+1];
      end else begin
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b1;
        start = 1'b0;
      end
      edges = 0;
      while (!done && edges < 10) begin
        tick();
        edges++;
      end
      check($sformatf("b2b%0d_lat", i), 65'(edges), 65'd4);
      check($sformatf("b2b%0d_sum", i), {cout, s}, {bb_co[i], bb_s[i]});
      check($sformatf("b2b%0d_ovf", i), 65'(overflow), 65'(bb_ov[i]));
      tick();
      check($sformatf("b2b%0d_next", i), 65'({done, busy}), (i < 2) ? 65'd1 : 65'd0);
    end

    // Reset during the second CALC cycle aborts with no done.
    a = 64'd1; b = 64'd1; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_sum", {cout, s}, 65'd0);
    check("abort_flags", 65'({overflow, busy, done}), 65'd0);
    seen_done = 0;
    repeat (6) begin
      tick();
      if (done) seen_done++;
    end
    check("abort_nodone", 65'(seen_done), 65'd0);
    do_op("after_abort", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1,
          64'd0, 1'b1, 1'b0);

    // Random sweep against a 65-bit reference sum.
    for (int n = 0; n < 1000; n++) begin
      ra   = {$urandom(), $urandom()};
      rb   = {$urandom(), $urandom()};
      rc   = 1'($urandom_range(1, 0));
      rsum = {1'b0, ra} + {1'b0, rb} + 65'(rc);
      rov  = (ra[63] == rb[63]) && (rsum[63] != ra[63]);
      do_op($sformatf("rnd%0d", n), ra, rb, rc, rsum[63:0], rsum[64], rov);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
